// File: rtl/enemy_grid_mover.sv
// enemy_grid_mover
//   Periodic enemy-movement engine for the tile map. On start it raster-scans
//   the GRID_W x GRID_H map through the shared grid port and moves each enemy
//   one tile into an adjacent air cell, trying up to MAX_TRIES directions.
//   Moved enemies are tagged MOVED_CODE so the scan cannot move them twice,
//   then a second raster pass turns every MOVED_CODE cell back into an enemy.
//   Passes closer than MOVE_PERIOD clocks apart are skipped (done still pulses).
//
//   Optional build macro ENEMY_MOVER_LFSR_EN: direction source becomes an 8-bit
//   Fibonacci LFSR (taps 8,6,5,4, seed 8'h01) instead of a 2-bit up-counter.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   start               pass request, sampled only in IDLE
//   done                one-cycle pulse when a request completes
//   busy                high in every state except IDLE
//   grid_x, grid_y      cell address
//   grid_out            cell contents, valid one clock after the address
//   grid_write, grid_in write strobe and data, committed at the clock edge
//   moved_count         enemies moved in the last accepted pass
module enemy_grid_mover #(
    parameter int GRID_W      = 40,
    parameter int GRID_H      = 30,
    parameter int XW          = 6,
    parameter int YW          = 5,
    parameter int CW          = 3,
    parameter int ENEMY_CODE  = 4,
    parameter int MOVED_CODE  = 5,
    parameter int AIR_CODE    = 0,
    parameter int MOVE_PERIOD = 200000,
    parameter int MAX_TRIES   = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic          busy,
    output logic [XW-1:0] grid_x,
    output logic [YW-1:0] grid_y,
    input  logic [CW-1:0] grid_out,
    output logic          grid_write,
    output logic [CW-1:0] grid_in,
    output logic [15:0]   moved_count
);
    localparam int TW = $clog2(MOVE_PERIOD + 1);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] GATE    = 4'd1;
    localparam logic [3:0] S_ADDR  = 4'd2;
    localparam logic [3:0] S_READ  = 4'd3;
    localparam logic [3:0] D_ADDR  = 4'd4;
    localparam logic [3:0] D_READ  = 4'd5;
    localparam logic [3:0] W_DEST  = 4'd6;
    localparam logic [3:0] W_SRC   = 4'd7;
    localparam logic [3:0] S_NEXT  = 4'd8;
    localparam logic [3:0] F_ADDR  = 4'd9;
    localparam logic [3:0] F_READ  = 4'd10;
    localparam logic [3:0] F_WRITE = 4'd11;
    localparam logic [3:0] F_NEXT  = 4'd12;
    localparam logic [3:0] DONE    = 4'd13;

    logic [3:0]    r_state;
    logic [XW-1:0] r_cx, r_sx, r_dx;
    logic [YW-1:0] r_cy, r_sy, r_dy;
    logic [1:0]    r_dir0;
    logic [2:0]    r_try;
    logic [15:0]   r_tally;
    logic [15:0]   r_moved;
    logic [TW-1:0] r_timer;
    logic [1:0]    w_dirsrc;

    // Direction source free-runs from reset regardless of state.
`ifdef ENEMY_MOVER_LFSR_EN
    logic [7:0] r_lfsr;
    always_ff @(posedge clock) begin
        if (reset) r_lfsr <= 8'h01;
        else       r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
    assign w_dirsrc = r_lfsr[1:0];
`else
    logic [1:0] r_dcnt;
    always_ff @(posedge clock) begin
        if (reset) r_dcnt <= 2'd0;
        else       r_dcnt <= r_dcnt + 2'd1;
    end
    assign w_dirsrc = r_dcnt;
`endif

    // Candidate destination for the current try; edge moves flag w_oob.
    logic [1:0]    w_dir;
    logic [XW-1:0] w_nx;
    logic [YW-1:0] w_ny;
    logic          w_oob;
    assign w_dir = r_dir0 + r_try[1:0];

    always_comb begin
        w_nx  = r_sx;
        w_ny  = r_sy;
        w_oob = 1'b0;
        case (w_dir)
            2'd0: if (r_sy == '0) w_oob = 1'b1; else w_ny = r_sy - 1'b1;
            2'd1: if (r_sx == XW'(GRID_W - 1)) w_oob = 1'b1; else w_nx = r_sx + 1'b1;
            2'd2: if (r_sy == YW'(GRID_H - 1)) w_oob = 1'b1; else w_ny = r_sy + 1'b1;
            default: if (r_sx == '0) w_oob = 1'b1; else w_nx = r_sx - 1'b1;
        endcase
    end

    logic w_last_cell, w_try_last, w_reload;
    assign w_last_cell = (r_cx == XW'(GRID_W - 1)) && (r_cy == YW'(GRID_H - 1));
    assign w_try_last  = (r_try == 3'(MAX_TRIES - 1));
    assign w_reload    = (r_state == GATE) && (r_timer == '0);

    // Grid port: cursor by default, destination while probing, source on W_SRC.
    always_comb begin
        grid_x     = r_cx;
        grid_y     = r_cy;
        grid_write = 1'b0;
        grid_in    = '0;
        case (r_state)
            D_ADDR:  begin grid_x = w_nx; grid_y = w_ny; end
            D_READ:  begin grid_x = r_dx; grid_y = r_dy; end
            W_DEST:  begin grid_x = r_dx; grid_y = r_dy; grid_write = 1'b1; grid_in = CW'(MOVED_CODE); end
            W_SRC:   begin grid_x = r_sx; grid_y = r_sy; grid_write = 1'b1; grid_in = CW'(AIR_CODE); end
            F_WRITE: begin grid_write = 1'b1; grid_in = CW'(ENEMY_CODE); end
            default: ;
        endcase
    end

    assign done        = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign moved_count = r_moved;

    // Period timer: saturating down-counter, reloaded when a pass is accepted.
    always_ff @(posedge clock) begin
        if (reset)              r_timer <= '0;
        else if (w_reload)      r_timer <= TW'(MOVE_PERIOD - 1);
        else if (r_timer != '0) r_timer <= r_timer - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cx <= '0; r_cy <= '0;
            r_sx <= '0; r_sy <= '0;
            r_dx <= '0; r_dy <= '0;
            r_dir0 <= '0; r_try <= '0;
            r_tally <= '0; r_moved <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) r_state <= GATE;
                GATE: begin
                    if (r_timer != '0) r_state <= DONE;
                    else begin
                        r_tally <= '0;
                        r_cx <= '0; r_cy <= '0;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: r_state <= S_READ;
                S_READ: begin
                    if (grid_out == CW'(ENEMY_CODE)) begin
                        r_sx <= r_cx; r_sy <= r_cy;
                        r_dir0 <= w_dirsrc;
                        r_try <= '0;
                        r_state <= D_ADDR;
                    end else r_state <= S_NEXT;
                end
                D_ADDR: begin
                    if (w_oob) begin
                        if (w_try_last) r_state <= S_NEXT;
                        else            r_try <= r_try + 3'd1;
                    end else begin
                        r_dx <= w_nx; r_dy <= w_ny;
                        r_state <= D_READ;
                    end
                end
                D_READ: begin
                    if (grid_out == CW'(AIR_CODE)) r_state <= W_DEST;
                    else if (w_try_last)           r_state <= S_NEXT;
                    else begin
                        r_try <= r_try + 3'd1;
                        r_state <= D_ADDR;
                    end
                end
                W_DEST: r_state <= W_SRC;
                W_SRC: begin
                    if (r_tally != 16'hFFFF) r_tally <= r_tally + 16'd1;
                    r_state <= S_NEXT;
                end
                S_NEXT, F_NEXT: begin
                    if (w_last_cell) begin
                        r_cx <= '0; r_cy <= '0;
                        if (r_state == S_NEXT) begin
                            r_moved <= r_tally;
                            r_state <= F_ADDR;
                        end else r_state <= DONE;
                    end else begin
                        if (r_cx == XW'(GRID_W - 1)) begin
                            r_cx <= '0;
                            r_cy <= r_cy + 1'b1;
                        end else r_cx <= r_cx + 1'b1;
                        r_state <= (r_state == S_NEXT) ? S_ADDR : F_ADDR;
                    end
                end
                F_ADDR: r_state <= F_READ;
                F_READ: r_state <= (grid_out == CW'(MOVED_CODE)) ? F_WRITE : F_NEXT;
                F_WRITE: r_state <= F_NEXT;
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
